max_pool_stage: RTL and testbench

MAX_POOL_STAGE -- requirements
Module: max_pool_stage

---
 rtl/max_pool_stage_pkg.sv | 23 ++
 rtl/max_pool_stage_if.sv | 37 +++
 rtl/max_pool_stage.sv | 96 +++++++++
 tb/tb_max_pool_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_stage_pkg.sv
// Shared constants, FSM state type and helpers for the 2x2 max-pool stage.
// Imported by the interface and the stage module.
package pool_pkg;

    localparam int PIX_W      = 8;
    localparam int FRAME_ROWS = 4;
    localparam int FRAME_COLS = 8;
    localparam int NUM_POOLED = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pool_state_e;

    // Unsigned maximum of two pixels.
    function automatic logic [PIX_W-1:0] max2(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_stage_if.sv
// Pixel-in / pooled-frame-out bundle for the max-pool stage.
// master drives pixels and consumes frames; slave is the stage.
interface max_pool_stage_if;
    import pool_pkg::*;

    logic                             in_valid;
    logic [PIX_W-1:0]                 in_pixel;
    logic                             in_last;
    logic                             in_ready;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_POOLED-1:0][PIX_W-1:0] pooledPixelArray;
    logic                             err_frame;

    modport master (
        output in_valid,
        output in_pixel,
        output in_last,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  pooledPixelArray,
        input  err_frame
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  in_last,
        output in_ready,
        output out_valid,
        input  out_ready,
        output pooledPixelArray,
        output err_frame
    );

endinterface

// File: rtl/max_pool_stage.sv
// 2x2 stride-2 max pooling over a 4x8 raster frame, producing 8 pooled
// pixels held until the downstream consumer takes the whole frame.
module max_pool_stage
    import pool_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    max_pool_stage_if.slave    bus
);

    pool_state_e                      state_q, state_d;
    logic [2:0]                       col_q, col_d;
    logic [1:0]                       row_q, row_d;
    logic [PIX_W-1:0]                 h_q, h_d;
    logic [3:0][PIX_W-1:0]            lb_q, lb_d;
    logic [NUM_POOLED-1:0][PIX_W-1:0] arr_q, arr_d;
    logic                             err_q, err_d;

    logic             at_end;
    logic [PIX_W-1:0] hmax;
    logic [1:0]       cp;

    assign at_end = (row_q == 2'd3) && (col_q == 3'd7);
    assign cp     = col_q[2:1];
    assign hmax   = max2(h_q, bus.in_pixel);

    assign bus.in_ready         = (state_q == FILL);
    assign bus.out_valid        = (state_q == HOLD);
    assign bus.pooledPixelArray = arr_q;
    assign bus.err_frame        = err_q;

    // Next state: accept pixels in FILL, pool them, hold frame until taken.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        h_d     = h_q;
        lb_d    = lb_q;
        arr_d   = arr_q;
        err_d   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    err_d = (bus.in_last != at_end);
                    if (bus.in_last && !at_end) begin
                        // Early end marker: drop the partial frame.
                        col_d = 3'd0;
                        row_d = 2'd0;
                    end else begin
                        if (!col_q[0]) begin
                            h_d = bus.in_pixel;
                        end else if (!row_q[0]) begin
                            lb_d[cp] = hmax;
                        end else begin
                            arr_d[{row_q[1], cp}] = max2(lb_q[cp], hmax);
                        end
                        col_d = col_q + 3'd1;
                        if (col_q == 3'd7) begin
                            row_d = row_q + 2'd1;
                        end
                        if (at_end) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            lb_q    <= '0;
            arr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            lb_q    <= lb_d;
            arr_q   <= arr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_max_pool_stage.sv
// Directed self-checking bench for max_pool_stage.
// Each task drives one scenario and checks it inline.
module tb_max_pool_stage;
    import pool_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    max_pool_stage_if bus ();

    max_pool_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [7:0][7:0] RAMP_EXP =
        {8'd31, 8'd29, 8'd27, 8'd25, 8'd15, 8'd13, 8'd11, 8'd9};
    localparam logic [7:0][7:0] SPARSE_EXP =
        {8'd77, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix_of(input int mode, input int i);
        if (mode == 0) return 8'(i);
        if (i == 0) return 8'd200;
        if (i == 22) return 8'd77;
        return 8'd0;
    endfunction

    task automatic send_pixel(input logic [7:0] p, input logic last);
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Sends pixels [first, n) of a frame; in_last on index 31 if last_ok.
    task automatic send_range(input int mode, input int first, input int n,
                              input bit gap, input bit last_ok);
        for (int i = first; i < n; i++) begin
            send_pixel(pix_of(mode, i), (i == 31) && last_ok);
            if (gap) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.err_frame !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got=%b%b exp=00",
                     bus.out_valid, bus.err_frame);
        end
        checks++;
        if (bus.pooledPixelArray !== 64'd0) begin
            failures++;
            $display("FAIL reset_array got=%h exp=0", bus.pooledPixelArray);
        end
    endtask

    task automatic test_ramp();
        bus.out_ready = 1'b1;
        send_range(0, 0, 31, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ramp_early_valid got=%b exp=0", bus.out_valid);
        end
        send_range(0, 31, 32, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ramp_latency got=%b%b exp=10",
                     bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.pooledPixelArray !== RAMP_EXP) begin
            failures++;
            $display("FAIL ramp_array got=%h exp=%h",
                     bus.pooledPixelArray, RAMP_EXP);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ramp_consume got=%b%b exp=01",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_sparse();
        send_range(1, 0, 32, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 ||
            bus.pooledPixelArray !== SPARSE_EXP) begin
            failures++;
            $display("FAIL sparse_array got=%b/%h exp=1/%h",
                     bus.out_valid, bus.pooledPixelArray, SPARSE_EXP);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        bus.out_ready = 1'b0;
        send_range(0, 0, 32, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.pooledPixelArray !== RAMP_EXP) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable bad_cycles=%0d exp=0 array=%h",
                     bad, bus.pooledPixelArray);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.pooledPixelArray !== RAMP_EXP) begin
            failures++;
            $display("FAIL hold_release got=%b%b/%h exp=01/%h",
                     bus.out_valid, bus.in_ready,
                     bus.pooledPixelArray, RAMP_EXP);
        end
        send_range(1, 0, 32, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 ||
            bus.pooledPixelArray !== SPARSE_EXP) begin
            failures++;
            $display("FAIL hold_next_frame got=%b/%h exp=1/%h",
                     bus.out_valid, bus.pooledPixelArray, SPARSE_EXP);
        end
        tick();
    endtask

    task automatic test_abort();
        send_range(0, 0, 10, 1'b0, 1'b1);
        send_pixel(8'd10, 1'b1);
        checks++;
        if (bus.err_frame !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_err got=%b%b exp=10",
                     bus.err_frame, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.err_frame !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse got=%b%b exp=00",
                     bus.err_frame, bus.out_valid);
        end
        send_range(0, 0, 31, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_realign got=%b exp=0", bus.out_valid);
        end
        send_range(0, 31, 32, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.pooledPixelArray !== RAMP_EXP) begin
            failures++;
            $display("FAIL abort_next got=%b/%h exp=1/%h",
                     bus.out_valid, bus.pooledPixelArray, RAMP_EXP);
        end
        tick();
    endtask

    task automatic test_missing_last();
        send_range(0, 0, 32, 1'b0, 1'b0);
        checks++;
        if (bus.err_frame !== 1'b1 || bus.out_valid !== 1'b1 ||
            bus.pooledPixelArray !== RAMP_EXP) begin
            failures++;
            $display("FAIL missing_last got=%b%b/%h exp=11/%h",
                     bus.err_frame, bus.out_valid,
                     bus.pooledPixelArray, RAMP_EXP);
        end
        tick();
        checks++;
        if (bus.err_frame !== 1'b0) begin
            failures++;
            $display("FAIL missing_last_pulse got=%b exp=0", bus.err_frame);
        end
    endtask

    task automatic test_reset_mid();
        send_range(0, 0, 20, 1'b0, 1'b1);
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.pooledPixelArray !== 64'd0 ||
            bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%b%b/%h exp=01/0",
                     bus.out_valid, bus.in_ready, bus.pooledPixelArray);
        end
        send_range(0, 0, 32, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.pooledPixelArray !== RAMP_EXP) begin
            failures++;
            $display("FAIL reset_mid_next got=%b/%h exp=1/%h",
                     bus.out_valid, bus.pooledPixelArray, RAMP_EXP);
        end
        tick();
    endtask

    task automatic test_gaps();
        bus.out_ready = 1'b0;
        send_range(1, 0, 32, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        send_range(0, 0, 32, 1'b1, 1'b1);
        checks++;
        if (bus.pooledPixelArray !== RAMP_EXP) begin
            failures++;
            $display("FAIL gaps_array got=%h exp=%h",
                     bus.pooledPixelArray, RAMP_EXP);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.err_frame !== 1'b0) begin
            failures++;
            $display("FAIL gaps_consumed got=%b%b exp=00",
                     bus.out_valid, bus.err_frame);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        test_reset();
        test_ramp();
        test_sparse();
        test_backpressure();
        test_abort();
        test_missing_last();
        test_reset_mid();
        test_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
